imem_responder: RTL

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: a program-loadable word memory that serves
// single outstanding fetch requests after a fixed number of wait states.
module imem_responder #(
  parameter int unsigned DEPTH = 4096,
  parameter logic [31:0] BASE  = 32'h0000_3000,
  parameter int unsigned WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_addr,
  output logic        rsp_err,
  input  logic        ld_we,
  input  logic [11:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        busy
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] LIMIT    = 33'(DEPTH) << 2;
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {
    IDLE_ST,
    WAIT_ST,
    RESP_ST
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_next;
  logic          w_accept;
  logic          w_enter_resp;
  logic [31:0]   r_rsp_instr;
  logic [31:0]   r_rsp_addr;
  logic          r_rsp_err;
  logic [31:0]   w_src_addr;
  logic [31:0]   w_offset;
  logic          w_err;
  logic [AW-1:0] w_rd_idx;
  logic [31:0]   w_rd_data;

  // Contents start at zero and survive reset, so a loaded program persists.
  logic [31:0] r_mem [DEPTH] = '{default: 32'h0};

  // NOTE: no reset on the memory array; resetting it would turn the RAM into
  // thousands of flops and would also wipe the loaded program.
  always_ff @(posedge clk) begin
    if (ld_we && (32'(ld_addr) < DEPTH)) begin
      r_mem[AW'(ld_addr)] <= ld_data;
    end
  end

  assign req_ready = reset && (r_state == IDLE_ST);
  assign w_accept  = req_valid && req_ready;

  // When the wait count is zero, capture happens on the acceptance edge,
  // before rsp_addr holds the request, so take the address straight from the port.
  assign w_src_addr = (r_state == IDLE_ST) ? req_addr : r_rsp_addr;
  assign w_offset   = w_src_addr - BASE;
  assign w_err      = (w_src_addr[1:0] != 2'b00) || (w_src_addr < BASE) ||
                      ({1'b0, w_offset} >= LIMIT);
  assign w_rd_idx   = w_offset[AW+1:2];
  assign w_rd_data  = r_mem[w_rd_idx];

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_next       = r_state;
    w_cnt_next   = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE_ST: begin
        if (w_accept) begin
          w_cnt_next = WAIT_CNT;
          if (WAIT_CNT == 4'd0) begin
            w_next       = RESP_ST;
            w_enter_resp = 1'b1;
          end else begin
            w_next = WAIT_ST;
          end
        end
      end
      WAIT_ST: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_next       = RESP_ST;
          w_enter_resp = 1'b1;
        end
      end
      RESP_ST: begin
        if (rsp_ready) begin
          w_next = IDLE_ST;
        end
      end
      default: w_next = IDLE_ST;
    endcase
  end

  // NOTE: non-blocking assignments make the capture read the memory word as it
  // was before this edge, so a load on the same edge does not reach the response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE_ST;
      r_cnt       <= 4'd0;
      r_rsp_instr <= 32'h0;
      r_rsp_addr  <= BASE;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_rsp_addr <= req_addr;
      end
      if (w_enter_resp) begin
        r_rsp_err   <= w_err;
        r_rsp_instr <= w_err ? 32'h0 : w_rd_data;
      end
    end
  end

  assign rsp_valid = (r_state == RESP_ST);
  assign busy      = (r_state != IDLE_ST);
  assign rsp_instr = r_rsp_instr;
  assign rsp_addr  = r_rsp_addr;
  assign rsp_err   = r_rsp_err;

endmodule
